fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 99 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: drains a FIFO read port into a BUF_DEPTH output buffer; rinc to out_valid is 2 cycles.
// Reads stop while buffered plus in-flight words fill the buffer; FIFO_RD_CNT_EN adds the rd_count output.
module fifo_rd_ctrl #(
  parameter int WIDTH     = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rempty,
  output logic             rinc,
  input  logic [WIDTH-1:0] rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]      rd_count
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CW:0] DEPTH_C = BUF_DEPTH[CW:0];

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [PW-1:0]    head_q, tail_q;
  logic             inflight_q;
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [CW:0]      level;
  logic             push, pop;

  // The in-flight word already owns a slot, so it counts against capacity.
  assign level     = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
  assign rinc      = !rst && (state_q == S_RUN) && !rempty && (level < DEPTH_C);
  assign push      = inflight_q;
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[head_q];
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_RUN;
      S_RUN:   if (!en) state_d = S_DRAIN;
      S_DRAIN: begin
        if (en) state_d = S_RUN;
        else if (!inflight_q && (occ_q == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= rinc;
      if (push) begin
        mem_q[tail_q] <= rdata;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 16'd1;
  end

  assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: vector table over one continuous run, then hand sequences for
// backpressure fill, reset with full buffer, reset with a word in flight, and the rd_count wrap.
module tb_fifo_rd_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, en, rempty, out_ready;
  logic         rinc, out_valid, busy;
  logic [W-1:0] rdata, out_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0]  rd_count;
`endif

  int           checks = 0;
  int           errors = 0;
  int           src_idx = 0;
  int           n;
  logic [W-1:0] exp_w;

  typedef struct {
    logic [2:0]  in;   // {en, rempty, out_ready}
    logic [2:0]  xp;   // {rinc, out_valid, busy}
    logic [15:0] dat;  // expected out_data when out_valid is expected
  } vec_t;
  vec_t tbl[28];

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.WIDTH(W), .BUF_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  function automatic logic [W-1:0] word(input int k);
    return 16'(32'h1111 * (k + 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic re, input logic rd);
    @(posedge clk);
    #1;
    en = e;
    rempty = re;
    out_ready = rd;
    @(negedge clk);
  endtask

  // FIFO model: the word requested by rinc appears on rdata the following cycle.
  always begin : src_model
    bit took;
    @(negedge clk);
    took = rinc;
    if (rempty) chk("rinc_while_empty", 32'(rinc), 32'd0);
    @(posedge clk);
    #1;
    if (took) begin
      rdata = word(src_idx);
      src_idx++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b101, 3'b000, 16'h0000};
    tbl[1]  = '{3'b101, 3'b101, 16'h0000};
    tbl[2]  = '{3'b101, 3'b101, 16'h0000};
    tbl[3]  = '{3'b101, 3'b011, 16'h1111};
    tbl[4]  = '{3'b101, 3'b111, 16'h2222};
    tbl[5]  = '{3'b101, 3'b101, 16'h0000};
    tbl[6]  = '{3'b101, 3'b011, 16'h3333};
    tbl[7]  = '{3'b100, 3'b111, 16'h4444};
    tbl[8]  = '{3'b100, 3'b011, 16'h4444};
    tbl[9]  = '{3'b100, 3'b011, 16'h4444};
    tbl[10] = '{3'b101, 3'b011, 16'h4444};
    tbl[11] = '{3'b101, 3'b111, 16'h5555};
    tbl[12] = '{3'b001, 3'b101, 16'h0000};
    tbl[13] = '{3'b001, 3'b011, 16'h6666};
    tbl[14] = '{3'b001, 3'b011, 16'h7777};
    tbl[15] = '{3'b001, 3'b001, 16'h0000};
    tbl[16] = '{3'b001, 3'b000, 16'h0000};
    tbl[17] = '{3'b101, 3'b000, 16'h0000};
    tbl[18] = '{3'b111, 3'b001, 16'h0000};
    tbl[19] = '{3'b101, 3'b101, 16'h0000};
    tbl[20] = '{3'b111, 3'b001, 16'h0000};
    tbl[21] = '{3'b101, 3'b111, 16'h8888};
    tbl[22] = '{3'b111, 3'b001, 16'h0000};
    tbl[23] = '{3'b101, 3'b111, 16'h9999};
    tbl[24] = '{3'b111, 3'b001, 16'h0000};
    tbl[25] = '{3'b011, 3'b011, 16'hAAAA};
    tbl[26] = '{3'b011, 3'b001, 16'h0000};
    tbl[27] = '{3'b011, 3'b000, 16'h0000};

    rst = 1'b1; en = 1'b0; rempty = 1'b1; out_ready = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rst_rd_count", 32'(rd_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("t%0d_rinc", i), 32'(rinc), 32'(tbl[i].xp[2]));
      chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].xp[1]));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].xp[0]));
      if (tbl[i].xp[1]) chk($sformatf("t%0d_out_data", i), 32'(out_data), 32'(tbl[i].dat));
    end
`ifdef FIFO_RD_CNT_EN
    chk("tbl_rd_count", 32'(rd_count), 32'd10);
`endif

    // Backpressure from empty: exactly two reads, head held, then drained in order.
    src_idx = 0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (rinc) n++;
    end
    chk("bp_rinc_pulses", 32'(n), 32'd2);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", 32'(out_data), 32'h1111);
    step(1'b0, 1'b0, 1'b1);
    chk("bp_pop0_data", 32'(out_data), 32'h1111);
    step(1'b0, 1'b0, 1'b1);
    chk("bp_pop1_valid", 32'(out_valid), 32'd1);
    chk("bp_pop1_data", 32'(out_data), 32'h2222);
    step(1'b0, 1'b0, 1'b1);
    chk("bp_empty_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset with a full buffer.
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0);
    chk("rfull_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rfull_rinc_in_rst", 32'(rinc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("rfull_out_valid", 32'(out_valid), 32'd0);
    chk("rfull_busy", 32'(busy), 32'd0);
    chk("rfull_rinc", 32'(rinc), 32'd0);
    chk("rfull_out_data", 32'(out_data), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rfull_rd_count", 32'(rd_count), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b1);
    chk("rfull_still_empty", 32'(out_valid), 32'd0);

    // Reset with a word in flight: it is discarded, then behaviour restarts as from power-up.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("rinf_rinc", 32'(rinc), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rinf_rinc_in_rst", 32'(rinc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rinf_first_rinc", 32'(rinc), 32'd0);
    chk("rinf_first_busy", 32'(busy), 32'd0);
    chk("rinf_first_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("rinf_restart_rinc", 32'(rinc), 32'd1);
    exp_w = word(src_idx);
    step(1'b1, 1'b0, 1'b1);
    chk("rinf_lat1_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("rinf_lat2_valid", 32'(out_valid), 32'd1);
    chk("rinf_lat2_data", 32'(out_data), 32'(exp_w));
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
    chk("rinf_end_busy", 32'(busy), 32'd0);

`ifdef FIFO_RD_CNT_EN
    // Counter wrap: 65537 pops from reset leave rd_count at 1.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b1;
    rempty = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 120000 && n < 65537; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
    end
    chk("cnt_pops_reached", 32'(n), 32'd65537);
    @(posedge clk);
    #1;
    en = 1'b0;
    chk("cnt_wrap", 32'(rd_count), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
